// File: rtl/result_display_pkg.sv
// Shared definitions for the result display path: operator codes, FSM state
// codes, display glyphs and their active-low {g,f,e,d,c,b,a} segment patterns.
package result_display_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        G_0 = 4'd0, G_1 = 4'd1, G_2 = 4'd2, G_3 = 4'd3, G_4 = 4'd4,
        G_5 = 4'd5, G_6 = 4'd6, G_7 = 4'd7, G_8 = 4'd8, G_9 = 4'd9,
        G_MINUS = 4'd10,
        G_E     = 4'd11,
        G_R     = 4'd12,
        G_BLANK = 4'd13
    } glyph_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph_seg(input glyph_t g);
        case (g)
            G_0:     glyph_seg = SEG_0;
            G_1:     glyph_seg = SEG_1;
            G_2:     glyph_seg = SEG_2;
            G_3:     glyph_seg = SEG_3;
            G_4:     glyph_seg = SEG_4;
            G_5:     glyph_seg = SEG_5;
            G_6:     glyph_seg = SEG_6;
            G_7:     glyph_seg = SEG_7;
            G_8:     glyph_seg = SEG_8;
            G_9:     glyph_seg = SEG_9;
            G_MINUS: glyph_seg = SEG_MINUS;
            G_E:     glyph_seg = SEG_E;
            G_R:     glyph_seg = SEG_R;
            default: glyph_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per cycle).
// Latency: 8 cycles after start; done is high during the final step cycle.
// Backpressure: none; a start while running restarts the conversion.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] adj;
    logic [2:0]  cnt;
    logic        run;

    always_comb begin
        adj = bcd_q;
        for (int n = 0; n < 3; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                run <= 1'b0;
            end
        end
    end

    assign done     = run && (cnt == 3'd7);
    assign hundreds = bcd_q[11:8];
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];

endmodule

// File: rtl/result_display.sv
// Captures a signed 8-bit result and shows it on a scanned 4-digit 7-segment display.
// Latency: display content changes 10 cycles after the accepted load edge.
// Backpressure: busy_o high during conversion; loads seen while busy are dropped.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result_i,
    input  logic       overflow_i,
    input  logic       load_i,
    output logic       busy_o,
    output logic [6:0] seg_o,
    output logic [3:0] an_o
);

    localparam int CW = $clog2(REFRESH_DIV);

    state_t state, state_nxt;
    logic   neg_q, ovf_q;
    logic   start;
    logic   bcd_done;
    logic [7:0] mag;
    logic [3:0] hundreds, tens, ones;
    glyph_t digit [4];

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx, idx_nxt;
    logic          wrap;

    assign start = (state == ST_IDLE) && load_i;
    // -128 negates to itself, which read as unsigned is the wanted 128.
    assign mag   = result_i[7] ? (~result_i + 8'd1) : result_i;

    bin2bcd_seq u_bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (mag),
        .done     (bcd_done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                neg_q <= result_i[7];
                ovf_q <= overflow_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (load_i) state_nxt = ST_CONVERT;
            ST_CONVERT: if (bcd_done) state_nxt = ST_COMMIT;
            ST_COMMIT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) digit[i] <= G_BLANK;
        end else if (state == ST_COMMIT) begin
            if (ovf_q) begin
                digit[3] <= G_E;
                digit[2] <= G_R;
                digit[1] <= G_R;
                digit[0] <= G_BLANK;
            end else begin
                digit[3] <= neg_q ? G_MINUS : G_BLANK;
                digit[2] <= (hundreds != 4'd0) ? glyph_t'(hundreds) : G_BLANK;
                digit[1] <= (hundreds != 4'd0 || tens != 4'd0) ? glyph_t'(tens) : G_BLANK;
                digit[0] <= glyph_t'(ones);
            end
        end
    end

    assign wrap    = (scan_cnt == CW'(REFRESH_DIV - 1));
    assign idx_nxt = wrap ? idx + 2'd1 : idx;

    // Outputs are driven from the next index so an_o and seg_o always match idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an_o     <= 4'b1110;
            seg_o    <= SEG_BLANK;
        end else begin
            scan_cnt <= wrap ? '0 : scan_cnt + CW'(1);
            idx      <= idx_nxt;
            an_o     <= ~(4'b0001 << idx_nxt);
            seg_o    <= glyph_seg(digit[idx_nxt]);
        end
    end

endmodule
